// File: rtl/serial_7in_framer_pkg.sv
// Shared sizing constants and bit-placement helper for the 7-bit serial framer.
package serial_7in_framer_pkg;

    localparam int              FRAME_BITS = 7;
    localparam int              CNT_W      = 3;
    localparam logic [CNT_W-1:0] CNT_FULL  = 3'd7;

    // Shift-register slot for the k-th accepted bit; sh[6] drives output a.
    function automatic logic [CNT_W-1:0] bit_pos(input logic [CNT_W-1:0] cnt,
                                                  input logic            msb_first);
        return msb_first ? (CNT_FULL - 3'd1 - cnt) : cnt;
    endfunction

endpackage

// File: rtl/serial_7in_framer_if.sv
// Serial-in / parallel-frame-out handshake bundle between producer, framer and ones-counter.
interface serial_7in_framer_if;

    logic clear;
    logic sin;
    logic sin_valid;
    logic sin_ready;
    logic a, b, c, d, e, f, g;
    logic frame_valid;
    logic out_ready;

    modport master (
        input  clear, sin, sin_valid, out_ready,
        output sin_ready, a, b, c, d, e, f, g, frame_valid
    );

    modport slave (
        output clear, sin, sin_valid, out_ready,
        input  sin_ready, a, b, c, d, e, f, g, frame_valid
    );

endinterface

// File: rtl/serial_7in_framer.sv
// Assembles a serial bit stream into 7-bit frames held on a..g for the ones-counter.
module serial_7in_framer
    import serial_7in_framer_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_7in_framer_if.master fi
);

    logic [FRAME_BITS-1:0] sh;
    logic [FRAME_BITS-1:0] outr;
    logic [CNT_W-1:0]      cnt;
    logic                  fv;

    logic                  full;
    logic                  accept;
    logic                  xfer;
    logic                  xfer_go;
    logic [CNT_W-1:0]      pos;

    assign full    = (cnt == CNT_FULL);
    assign accept  = fi.sin_valid && !full;
    assign xfer    = full && (!fv || fi.out_ready);
    // clear beats transfer: a flushed frame must never reach the output slot
    assign xfer_go = xfer && !fi.clear;
    assign pos     = bit_pos(cnt, MSB_FIRST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh   <= '0;
            outr <= '0;
            cnt  <= '0;
            fv   <= 1'b0;
        end else begin
            if (fi.clear) begin
                sh  <= '0;
                cnt <= '0;
            end else if (xfer) begin
                outr <= sh;
                sh   <= '0;
                cnt  <= '0;
            end else if (accept) begin
                sh[pos] <= fi.sin;
                cnt     <= cnt + 3'd1;
            end

            // a transfer refills the slot in the same edge it is consumed
            if (xfer_go)
                fv <= 1'b1;
            else if (fv && fi.out_ready)
                fv <= 1'b0;
        end
    end

    assign fi.sin_ready   = !full;
    assign fi.frame_valid = fv;
    assign {fi.a, fi.b, fi.c, fi.d, fi.e, fi.f, fi.g} = outr;

endmodule

// File: tb/tb_serial_7in_framer.sv
// Directed scoreboard bench: one MSB-first and one LSB-first framer share the stimulus.
module tb_serial_7in_framer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sin = 1'b0, sin_valid = 1'b0, out_ready = 1'b0, clear = 1'b0;

    always #5 clk = ~clk;

    serial_7in_framer_if if_m ();
    serial_7in_framer_if if_l ();

    assign if_m.clear = clear;  assign if_l.clear = clear;
    assign if_m.sin = sin;      assign if_l.sin = sin;
    assign if_m.sin_valid = sin_valid;  assign if_l.sin_valid = sin_valid;
    assign if_m.out_ready = out_ready;  assign if_l.out_ready = out_ready;

    serial_7in_framer #(.MSB_FIRST(1'b1)) u_m (.clk(clk), .rst_n(rst_n), .fi(if_m));
    serial_7in_framer #(.MSB_FIRST(1'b0)) u_l (.clk(clk), .rst_n(rst_n), .fi(if_l));

    typedef struct {
        logic [6:0] bits;
        logic [2:0] ones;
    } exp_t;

    exp_t q_m[$];
    exp_t q_l[$];
    int   errors = 0;
    int   checks = 0;

    logic [6:0] out_m, out_l;
    assign out_m = {if_m.a, if_m.b, if_m.c, if_m.d, if_m.e, if_m.f, if_m.g};
    assign out_l = {if_l.a, if_l.b, if_l.c, if_l.d, if_l.e, if_l.f, if_l.g};

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    task automatic push(logic [6:0] m, logic [6:0] l, logic [2:0] n);
        q_m.push_back('{bits: m, ones: n});
        q_l.push_back('{bits: l, ones: n});
    endtask

    // Monitor: every consumed frame is popped and compared, incl. ones-count.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_ready) begin
            if (if_m.frame_valid) begin
                if (q_m.size() == 0) chk("msb_unexpected_frame", {25'd0, out_m}, 32'hffff_ffff);
                else begin
                    e = q_m.pop_front();
                    chk("msb_frame", {25'd0, out_m}, {25'd0, e.bits});
                    chk("msb_ones", $countones(out_m), {29'd0, e.ones});
                end
            end
            if (if_l.frame_valid) begin
                if (q_l.size() == 0) chk("lsb_unexpected_frame", {25'd0, out_l}, 32'hffff_ffff);
                else begin
                    e = q_l.pop_front();
                    chk("lsb_frame", {25'd0, out_l}, {25'd0, e.bits});
                    chk("lsb_ones", $countones(out_l), {29'd0, e.ones});
                end
            end
        end
    end

    // Holds sin/sin_valid until the framer accepts; returns at posedge+1.
    task automatic send_bit(logic bv);
        logic r;
        int   n;
        n = 0;
        sin = bv;
        sin_valid = 1'b1;
        do begin
            @(negedge clk);
            r = if_m.sin_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!r && n < 50);
        if (!r) chk("send_timeout", 0, 1);
    endtask

    task automatic send7(logic [6:0] v);
        for (int i = 6; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic idle(int n);
        sin_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset
        #3;
        chk("rst_fv", if_m.frame_valid, 0);
        chk("rst_out", {25'd0, out_m}, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_ready", if_m.sin_ready, 1);
        chk("idle_fv", if_l.frame_valid, 0);
        chk("idle_out", {25'd0, out_l}, 0);

        // basic frame and latency
        out_ready = 1'b1;
        push(7'b1010011, 7'b1100101, 3'd4);
        send7(7'b1010011);
        chk("lat_fv_lo", if_m.frame_valid, 0);
        chk("lat_ready_lo", if_m.sin_ready, 0);
        sin_valid = 1'b0;
        @(posedge clk); #1;
        chk("lat_fv_hi", if_m.frame_valid, 1);
        chk("lat_ready_hi", if_m.sin_ready, 1);
        idle(2);
        chk("drain_fv", if_m.frame_valid, 0);

        // backpressure: 14 bits with out_ready low
        out_ready = 1'b0;
        push(7'b1101000, 7'b0001011, 3'd3);
        push(7'b0011101, 7'b1011100, 3'd4);
        send7(7'b1101000);
        send7(7'b0011101);
        chk("bp_ready_lo", if_m.sin_ready, 0);
        chk("bp_fv", if_m.frame_valid, 1);
        chk("bp_hold1", {25'd0, out_m}, 7'b1101000);
        idle(3);
        chk("bp_hold2", {25'd0, out_m}, 7'b1101000);
        chk("bp_ready_lo2", if_l.sin_ready, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_fv_b2b", if_m.frame_valid, 1);
        chk("bp_ready_hi", if_m.sin_ready, 1);
        chk("bp_frame2", {25'd0, out_m}, 7'b0011101);
        idle(2);

        // clear mid-frame discards partial bits and the same-cycle sin
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        clear = 1'b1; sin = 1'b0; sin_valid = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        chk("clr_ready", if_m.sin_ready, 1);
        push(7'b1111111, 7'b1111111, 3'd7);
        send7(7'b1111111);
        idle(3);

        // gapped input
        push(7'b1100001, 7'b1000011, 3'd3);
        begin
            logic [6:0] gv;
            gv = 7'b1100001;
            for (int i = 6; i >= 0; i--) begin
                send_bit(gv[i]);
                if (i != 0) begin
                    sin_valid = 1'b0;
                    sin = ~gv[i];
                    @(posedge clk); #1;
                    chk("gap_fv_lo", if_m.frame_valid, 0);
                end
            end
        end
        sin_valid = 1'b0;
        @(posedge clk); #1;
        chk("gap_fv_hi", if_l.frame_valid, 1);
        idle(3);

        // clear beats transfer; presented frame survives clear
        out_ready = 1'b0;
        push(7'b0101011, 7'b1101010, 3'd4);
        send7(7'b0101011);
        send7(7'b1111000);
        sin_valid = 1'b0;
        chk("pri_stall", if_m.sin_ready, 0);
        clear = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        chk("pri_fv_lo", if_m.frame_valid, 0);
        chk("pri_ready", if_m.sin_ready, 1);
        chk("pri_out_kept", {25'd0, out_m}, 7'b0101011);
        idle(3);
        chk("pri_no_frame", if_l.frame_valid, 0);

        // async reset mid-frame
        out_ready = 1'b0;
        send7(7'b1001001);
        idle(1);
        chk("arst_pre_fv", if_m.frame_valid, 1);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        sin_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_fv", if_m.frame_valid, 0);
        chk("arst_out_m", {25'd0, out_m}, 0);
        chk("arst_out_l", {25'd0, out_l}, 0);
        chk("arst_ready", if_l.sin_ready, 1);
        @(negedge clk) rst_n = 1'b1;
        idle(2);

        chk("q_m_empty", q_m.size(), 0);
        chk("q_l_empty", q_l.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
